// File: rtl/sync_fifo_flags_pkg.sv
// Shared types and elaboration helpers for the single-clock flagged FIFO.
// Pure definitions; no logic.
package sync_fifo_flags_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } flags_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_t;

endpackage

// File: rtl/sync_fifo_flags_ram.sv
// DATA_W x DEPTH storage: one write port, one registered read port with enable.
// Latency: read data 1 cycle after rd_en; no backpressure (caller guarantees legal ops).
module sync_fifo_flags_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  // Only the output register is reset; the array keeps stale contents.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with count, almost-full/empty and sticky error flags; FIFO_FWFT_EN selects fall-through reads.
// Latency: 1 cycle read (standard) or head always presented (FWFT); writes while full / reads while empty are dropped and flagged.
module sync_fifo_flags
  import sync_fifo_flags_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 64,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam logic [AW:0] AF_C = AF_THRESH[AW:0];
  localparam logic [AW:0] AE_C = AE_THRESH[AW:0];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  flags_t      flg_q, flg_d;
  err_t        err_q, err_d;
  logic        wr_acc, rd_acc;

  logic              ram_we;
  logic              ram_re;
  logic [AW-1:0]     ram_raddr;
  logic [DATA_W-1:0] ram_rd_data;

  always_comb begin
    wr_acc   = wr_en & ~flg_q.full;
    rd_acc   = rd_en & ~flg_q.empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_acc};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_acc};
    count_d  = wr_ptr_d - rd_ptr_d;

    flg_d.empty        = (wr_ptr_d == rd_ptr_d);
    flg_d.full         = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    flg_d.almost_full  = (count_d >= AF_C);
    flg_d.almost_empty = (count_d <= AE_C);

    // A fresh error outranks a clear issued in the same cycle.
    err_d.overflow  = (wr_en & flg_q.full)  | (err_q.overflow  & ~clr_err);
    err_d.underflow = (rd_en & flg_q.empty) | (err_q.underflow & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flg_q    <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flg_q    <= flg_d;
      err_q    <= err_d;
    end
  end

  assign ram_we = wr_acc & ~rst;

`ifdef FIFO_FWFT_EN
  logic              byp_q, byp_d;
  logic [DATA_W-1:0] byp_dat_q, byp_dat_d;

  // Prefetch the next head every cycle; when that head is the word being
  // written right now, the array cannot return it yet, so forward it.
  always_comb begin
    ram_re    = ~flg_d.empty;
    ram_raddr = rd_ptr_d[AW-1:0];
    byp_d     = wr_acc & (wr_ptr_q == rd_ptr_d);
    byp_dat_d = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q     <= 1'b0;
      byp_dat_q <= '0;
    end else begin
      byp_q     <= byp_d;
      byp_dat_q <= byp_dat_d;
    end
  end

  assign rd_data  = byp_q ? byp_dat_q : ram_rd_data;
  assign rd_valid = ~flg_q.empty;
`else
  logic rd_valid_q, rd_valid_d;

  always_comb begin
    ram_re     = rd_acc;
    ram_raddr  = rd_ptr_q[AW-1:0];
    rd_valid_d = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= rd_valid_d;
  end

  assign rd_data  = ram_rd_data;
  assign rd_valid = rd_valid_q;
`endif

  sync_fifo_flags_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (ram_rd_data)
  );

  assign full         = flg_q.full;
  assign empty        = flg_q.empty;
  assign almost_full  = flg_q.almost_full;
  assign almost_empty = flg_q.almost_empty;
  assign count        = count_q;
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: vector table, directed corner sequences, randomized traffic vs a queue model.
module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int AF    = DEPTH - 4;
  localparam int AE    = 4;
`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty;
  logic [6:0]    count;
  logic          overflow, underflow;

  always #5 clk = ~clk;

  sync_fifo_flags dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: contents as a queue, errors and read port as plain state.
  logic [DW-1:0] mq[$];
  bit            m_ovf, m_unf, m_rdv;
  logic [DW-1:0] m_rdd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit w, input logic [DW-1:0] d, input bit rd, input bit c);
    bit was_full, was_empty, wacc, racc;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    wacc = w && !was_full;
    racc = rd && !was_empty;
    if (r) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_rdv = 0; m_rdd = '0;
    end else begin
      if (!FWFT) begin
        m_rdv = racc;
        if (racc) m_rdd = mq[0];
      end
      if (racc) void'(mq.pop_front());
      if (wacc) mq.push_back(d);
      m_ovf = (w && was_full)  ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_unf = (rd && was_empty) ? 1'b1 : (c ? 1'b0 : m_unf);
      if (FWFT) begin
        m_rdv = (mq.size() != 0);
        if (m_rdv) m_rdd = mq[0];
      end
    end
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
    if (!FWFT || m_rdv) chk("rd_data", 32'(rd_data), 32'(m_rdd));
  endtask

  task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit rd, input bit c);
    rst = r; wr_en = w; wr_data = d; rd_en = rd; clr_err = c;
    model_step(r, w, d, rd, c);
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    bit            rst, wr, rd, clr;
    logic [DW-1:0] dat;
    int            exp_cnt;
    bit            exp_empty, exp_unf, exp_rdv_std, exp_rdv_fwft;
    logic [DW-1:0] exp_dat;
  } vec_t;

  vec_t vt[7];

  initial begin
    // reset, idle, underflow, read+write on empty, clear, pop, idle
    vt[0] = '{1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00};
    vt[1] = '{0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00};
    vt[2] = '{0, 0, 1, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00};
    vt[3] = '{0, 1, 1, 0, 8'h55, 1, 0, 1, 0, 1, 8'h55};
    vt[4] = '{0, 0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 8'h55};
    vt[5] = '{0, 0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 8'h55};
    vt[6] = '{0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h55};

    for (int i = 0; i < 7; i++) begin
      bit erdv;
      step(vt[i].rst, vt[i].wr, vt[i].dat, vt[i].rd, vt[i].clr);
      erdv = FWFT ? vt[i].exp_rdv_fwft : vt[i].exp_rdv_std;
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].exp_cnt));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].exp_empty));
      chk($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vt[i].exp_unf));
      chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(erdv));
      if (erdv) chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vt[i].exp_dat));
    end

    // Fill to full with 1..64 and watch the threshold flags, then drain in order.
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= DEPTH; k++) begin
      step(0, 1, DW'(k), 0, 0);
      chk("fill_almost_full", 32'(almost_full), 32'(k >= 60));
      chk("fill_full", 32'(full), 32'(k == 64));
    end
    for (int k = 1; k <= DEPTH; k++) begin
      if (FWFT) chk("drain_head", 32'(rd_data), 32'(k));
      step(0, 0, 0, 1, 0);
      if (!FWFT) chk("drain_order", 32'(rd_data), 32'(k));
    end
    chk("drain_empty", 32'(empty), 32'(1));

    // Writes while full are rejected, even alongside an accepted read.
    for (int k = 1; k <= DEPTH; k++) step(0, 1, DW'(8'h80 + k), 0, 0);
    step(0, 1, 8'hAA, 0, 0);
    chk("ovf_set", 32'(overflow), 32'(1));
    chk("ovf_count", 32'(count), 32'(64));
    step(0, 0, 0, 0, 1);
    chk("ovf_clr", 32'(overflow), 32'(0));
    step(0, 1, 8'hAA, 1, 0);
    chk("ovf_with_read_count", 32'(count), 32'(63));
    chk("ovf_with_read_flag", 32'(overflow), 32'(1));
    step(0, 0, 0, 0, 1);
    while (mq.size() != 0) step(0, 0, 0, 1, 0);

    // Steady state at count 10 across many pointer wraps.
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 1, DW'(k), 0, 0);
    for (int k = 0; k < 100; k++) step(0, 1, DW'(8'h10 + k), 1, 0);
    chk("steady_count", 32'(count), 32'(10));
    for (int k = 0; k < 10; k++) step(0, 0, 0, 1, 0);

    // Single word round trip.
    step(1, 0, 0, 0, 0);
    step(0, 1, 8'h33, 0, 0);
    if (!FWFT) step(0, 0, 0, 1, 0);
    chk("single_rd_data", 32'(rd_data), 32'h33);
    chk("single_rd_valid", 32'(rd_valid), 32'(1));

    // Randomized traffic in write-heavy, read-heavy and balanced phases.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int phase, pw, pr;
      bit r, w, rd, c;
      phase = (i / 200) % 3;
      pw = (phase == 0) ? 80 : (phase == 1) ? 30 : 50;
      pr = (phase == 0) ? 30 : (phase == 1) ? 80 : 50;
      r  = ($urandom_range(0, 299) == 0);
      w  = ($urandom_range(0, 99) < pw);
      rd = ($urandom_range(0, 99) < pr);
      c  = ($urandom_range(0, 99) < 5);
      step(r, w, DW'($urandom), rd, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
